// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings and defaults for the core control sequencer.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_FAULT  = 3'd6
  } state_e;

  localparam int MEM_TIMEOUT_DEF = 15;

  localparam logic PC_SEQ = 1'b0;
  localparam logic PC_BR  = 1'b1;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles and flags when the allowed wait budget is used up.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic [CNT_W-1:0] count_q;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples its inputs from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (count_en_i) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign expired_o = (count_q == CNT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM: fetch, decode, execute, memory and write-back
// strobes for the single-issue core, plus wait timeout and retire counter.
module cpu_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_branch,
  input  logic        dec_load_store,
  input  logic        dec_data_reg,
  input  logic        dec_data_imm,
  input  logic        dec_set_flags,
  input  logic        dec_halt,
  input  logic        dec_is_store,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_instr,
  output logic        ir_load,
  output logic        rf_rd,
  output logic        alu_en,
  output logic        flags_en,
  output logic        rf_we,
  output logic        pc_en,
  output logic        pc_sel,
  output logic        halted,
  output logic        fault,
  output logic [2:0]  state,
  output logic [31:0] instr_count
);

  state_e      state_q, state_d;
  logic [31:0] instr_count_q, instr_count_d;
  logic        retire;
  logic        any_class;
  logic        in_mem_phase;
  logic        tmr_expired;

  assign any_class    = dec_branch | dec_load_store | dec_data_reg | dec_data_imm;
  assign in_mem_phase = (state_q == ST_FETCH) || (state_q == ST_MEM);

  // Any state change clears the timer, which covers every entry into FETCH/MEM.
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk        (clk),
    .rst_n      (rst),
    .clear_i    (state_d != state_q),
    .count_en_i (in_mem_phase && !mem_ready),
    .expired_o  (tmr_expired)
  );

  // NOTE: every signal written here gets a default first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_instr = 1'b0;
    ir_load   = 1'b0;
    rf_rd     = 1'b0;
    alu_en    = 1'b0;
    flags_en  = 1'b0;
    rf_we     = 1'b0;
    pc_en     = 1'b0;
    pc_sel    = PC_SEQ;

    case (state_q)
      ST_FETCH: begin
        mem_req   = 1'b1;
        mem_instr = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          state_d = ST_DECODE;
        end else if (tmr_expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: begin
        rf_rd = 1'b1;
        if (dec_halt)        state_d = ST_HALT;
        else if (!any_class) state_d = ST_FAULT;
        else                 state_d = ST_EXEC;
      end
      ST_EXEC: begin
        alu_en   = 1'b1;
        flags_en = dec_set_flags & (dec_data_reg | dec_data_imm);
        if (dec_branch) begin
          pc_en   = 1'b1;
          pc_sel  = branch_taken ? PC_BR : PC_SEQ;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else if (dec_load_store) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = dec_is_store;
        if (mem_ready) begin
          if (dec_is_store) begin
            pc_en   = 1'b1;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (tmr_expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_WB: begin
        rf_we   = 1'b1;
        pc_en   = 1'b1;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT:  state_d = ST_HALT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase
  end

  assign instr_count_d = retire ? instr_count_q + 32'd1 : instr_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_FETCH;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign state       = state_q;
  assign instr_count = instr_count_q;
  assign halted      = (state_q == ST_HALT);
  assign fault       = (state_q == ST_FAULT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer: instruction classes, memory
// waits, timeout, halt, illegal decode, counter wrap and asynchronous reset.
module tb_cpu_sequencer;

  logic        clk;
  logic        rst;
  logic        dec_branch, dec_load_store, dec_data_reg, dec_data_imm;
  logic        dec_set_flags, dec_halt, dec_is_store, branch_taken, mem_ready;
  logic        mem_req, mem_we, mem_instr, ir_load, rf_rd, alu_en, flags_en;
  logic        rf_we, pc_en, pc_sel, halted, fault;
  logic [2:0]  state;
  logic [31:0] instr_count;

  int checks   = 0;
  int failures = 0;

  // Strobe vector order:
  // mem_req mem_we mem_instr ir_load | rf_rd alu_en flags_en rf_we | pc_en pc_sel halted fault
  localparam logic [11:0] S_FETCH_WAIT = 12'b1010_0000_0000;
  localparam logic [11:0] S_FETCH_RDY  = 12'b1011_0000_0000;
  localparam logic [11:0] S_DECODE     = 12'b0000_1000_0000;
  localparam logic [11:0] S_EXEC       = 12'b0000_0100_0000;
  localparam logic [11:0] S_EXEC_FLAGS = 12'b0000_0110_0000;
  localparam logic [11:0] S_BR_TAKEN   = 12'b0000_0100_1100;
  localparam logic [11:0] S_BR_NOT     = 12'b0000_0100_1000;
  localparam logic [11:0] S_MEM_LOAD   = 12'b1000_0000_0000;
  localparam logic [11:0] S_MEM_ST_RDY = 12'b1100_0000_1000;
  localparam logic [11:0] S_WB         = 12'b0000_0001_1000;
  localparam logic [11:0] S_HALT       = 12'b0000_0000_0010;
  localparam logic [11:0] S_FAULT      = 12'b0000_0000_0001;

  cpu_sequencer #(.MEM_TIMEOUT(15)) dut (
    .clk            (clk),
    .rst            (rst),
    .dec_branch     (dec_branch),
    .dec_load_store (dec_load_store),
    .dec_data_reg   (dec_data_reg),
    .dec_data_imm   (dec_data_imm),
    .dec_set_flags  (dec_set_flags),
    .dec_halt       (dec_halt),
    .dec_is_store   (dec_is_store),
    .branch_taken   (branch_taken),
    .mem_ready      (mem_ready),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_instr      (mem_instr),
    .ir_load        (ir_load),
    .rf_rd          (rf_rd),
    .alu_en         (alu_en),
    .flags_en       (flags_en),
    .rf_we          (rf_we),
    .pc_en          (pc_en),
    .pc_sel         (pc_sel),
    .halted         (halted),
    .fault          (fault),
    .state          (state),
    .instr_count    (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "bench did not finish");
  end

  function automatic logic [11:0] strobes();
    return {mem_req, mem_we, mem_instr, ir_load, rf_rd, alu_en, flags_en,
            rf_we, pc_en, pc_sel, halted, fault};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_st(input string tag, input logic [2:0] exp_state, input logic [11:0] exp_strb);
    #1;
    check({tag, "_state"}, {29'd0, state}, {29'd0, exp_state});
    check({tag, "_strobes"}, {20'd0, strobes()}, {20'd0, exp_strb});
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_dec(input logic b, input logic ls, input logic r, input logic i,
                         input logic sf, input logic h, input logic st, input logic tk);
    dec_branch     = b;
    dec_load_store = ls;
    dec_data_reg   = r;
    dec_data_imm   = i;
    dec_set_flags  = sf;
    dec_halt       = h;
    dec_is_store   = st;
    branch_taken   = tk;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst       = 1'b0;
    mem_ready = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    // Reset state
    check_st("reset", 3'd0, S_FETCH_WAIT);
    check("reset_count", instr_count, 32'd0);
    rst = 1'b1;

    // Data-imm with flags, zero-wait fetch: 0,1,2,4,0
    set_dec(0, 0, 0, 1, 1, 0, 0, 0);
    mem_ready = 1'b1;
    check_st("imm_fetch", 3'd0, S_FETCH_RDY);
    tick(); check_st("imm_decode", 3'd1, S_DECODE);
    tick(); check_st("imm_exec", 3'd2, S_EXEC_FLAGS);
    tick(); check_st("imm_wb", 3'd4, S_WB);
    check("imm_count_pre", instr_count, 32'd0);
    tick(); check_st("imm_back", 3'd0, S_FETCH_RDY);
    check("imm_count_post", instr_count, 32'd1);

    // Branch taken, set_flags ignored for branch class
    set_dec(1, 0, 0, 0, 1, 0, 0, 1);
    tick(); check_st("brt_decode", 3'd1, S_DECODE);
    tick(); check_st("brt_exec", 3'd2, S_BR_TAKEN);
    tick(); check_st("brt_back", 3'd0, S_FETCH_RDY);
    check("brt_count", instr_count, 32'd2);

    // Branch not taken
    set_dec(1, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick(); check_st("brn_exec", 3'd2, S_BR_NOT);
    tick(); check("brn_count", instr_count, 32'd3);

    // Load with three wait cycles in MEM
    set_dec(0, 1, 0, 0, 0, 0, 0, 0);
    tick(); tick(); check_st("ld_exec", 3'd2, S_EXEC);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); check_st("ld_mem_wait", 3'd3, S_MEM_LOAD);
    end
    tick();
    mem_ready = 1'b1;
    check_st("ld_mem_rdy", 3'd3, S_MEM_LOAD);
    tick(); check_st("ld_wb", 3'd4, S_WB);
    tick(); check("ld_count", instr_count, 32'd4);

    // Store, zero-wait: no WB
    set_dec(0, 1, 0, 0, 0, 0, 1, 0);
    tick(); tick(); tick();
    check_st("st_mem", 3'd3, S_MEM_ST_RDY);
    tick(); check_st("st_back", 3'd0, S_FETCH_RDY);
    check("st_count", instr_count, 32'd5);

    // Fetch timeout: 16 cycles with no ready -> FAULT, sticky
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check_st("to_last_wait", 3'd0, S_FETCH_WAIT);
    tick(); check_st("to_fault", 3'd6, S_FAULT);
    mem_ready = 1'b1;
    tick(); tick(); check_st("to_sticky", 3'd6, S_FAULT);

    // Ready on the expiry cycle wins
    mem_ready = 1'b0;
    pulse_reset();
    check("rst2_count", instr_count, 32'd0);
    for (int i = 0; i < 15; i++) tick();
    mem_ready = 1'b1;
    check_st("exp_rdy", 3'd0, S_FETCH_RDY);
    set_dec(0, 0, 1, 0, 0, 1, 0, 0);
    // Halt together with data-reg
    tick(); check_st("halt_decode", 3'd1, S_DECODE);
    tick(); check_st("halt_enter", 3'd5, S_HALT);
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      tick(); check_st("halt_hold", 3'd5, S_HALT);
    end
    check("halt_count", instr_count, 32'd0);

    // Illegal instruction: no class bit
    mem_ready = 1'b1;
    set_dec(0, 0, 0, 0, 1, 0, 0, 0);
    pulse_reset();
    tick(); check_st("illegal_decode", 3'd1, S_DECODE);
    tick(); check_st("illegal_fault", 3'd6, S_FAULT);

    // Retire counter wrap
    pulse_reset();
    force dut.instr_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.instr_count_q;
    check("wrap_pre", instr_count, 32'hFFFF_FFFF);
    set_dec(1, 0, 0, 0, 0, 0, 0, 1);
    tick(); tick(); tick();
    check("wrap_post", instr_count, 32'd0);

    // Data-reg without flags, then asynchronous reset in the middle of MEM
    set_dec(0, 0, 1, 0, 0, 0, 0, 0);
    tick(); tick(); check_st("reg_exec", 3'd2, S_EXEC);
    tick(); tick();
    check("reg_count", instr_count, 32'd1);
    set_dec(0, 1, 0, 0, 0, 0, 0, 0);
    tick(); tick(); tick();
    mem_ready = 1'b0;
    check_st("arst_pre", 3'd3, S_MEM_LOAD);
    rst = 1'b0;
    check_st("arst_now", 3'd0, S_FETCH_WAIT);
    check("arst_count", instr_count, 32'd0);
    tick();
    rst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control FSM that sequences the single-issue core around the instruction decoder. It fetches an instruction over the shared memory port, then reads the decoder's class outputs (branch / load-store / data-register / data-immediate / halt). From those it steps through execute, memory and write-back, generating every enable strobe for the IR, register file, ALU, flags, memory port and PC. It also owns a memory-wait timeout and a retired-instruction counter.

## Interface
Parameters:
- MEM_TIMEOUT, 15, maximum wait cycles for mem_ready in FETCH or MEM before FAULT (must be ≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- dec_branch  in  1  decoder: branch class
- dec_load_store  in  1  decoder: load/store class
- dec_data_reg  in  1  decoder: data-register class
- dec_data_imm  in  1  decoder: data-immediate class
- dec_set_flags  in  1  decoder: set-flags bit
- dec_halt  in  1  decoder: halt pattern
- dec_is_store  in  1  1 = store, 0 = load; valid with dec_load_store
- branch_taken  in  1  condition unit result for the current branch
- mem_ready  in  1  memory port completes the current request this cycle
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_instr  out  1  1 = instruction fetch, 0 = data access
- ir_load  out  1  capture instruction register
- rf_rd  out  1  register-file read enable
- alu_en  out  1  ALU operand/result capture
- flags_en  out  1  flag register update
- rf_we  out  1  register-file write
- pc_en  out  1  PC update
- pc_sel  out  1  0 = PC+4, 1 = branch target
- halted  out  1  sticky halt indication
- fault  out  1  sticky fault indication
- state  out  3  current state encoding
- instr_count  out  32  retired-instruction counter

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, FAULT=6. Encoding 7 is unreachable and transitions to FAULT.
- FETCH: mem_req=1, mem_we=0, mem_instr=1. When mem_ready=1, ir_load=1 in the same cycle, then go to DECODE.
- DECODE: rf_rd=1. Transitions are evaluated in this priority order:
  - dec_halt → HALT (halt wins over everything else).
  - No class bit set → FAULT (illegal instruction).
  - Otherwise → EXEC.
- EXEC: alu_en=1. flags_en = dec_set_flags & (dec_data_reg | dec_data_imm).
  - Branch: pc_en=1, pc_sel=branch_taken, retire, → FETCH.
  - Load/store: → MEM.
  - Otherwise: → WB.
- MEM: mem_req=1, mem_instr=0, mem_we=dec_is_store. When mem_ready=1:
  - Store: pc_en=1, pc_sel=0, retire, → FETCH.
  - Load: → WB.
- WB: rf_we=1, pc_en=1, pc_sel=0, retire, → FETCH.
- HALT: halted=1, all strobes 0; sticky until reset.
- FAULT: fault=1, all strobes 0; sticky until reset.
- Decoder inputs are sampled combinationally each cycle. The IR holds them stable from DECODE through WB.
- Retire: instr_count += 1 (mod 2^32), wrapping 0xFFFFFFFF → 0. A halt instruction does not retire.
- Wait timer:
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle spent in FETCH/MEM with mem_ready=0.
  - If the timer equals MEM_TIMEOUT and mem_ready=0 → FAULT.
  - If mem_ready=1 in that same cycle, completion wins.
  - Width: $clog2(MEM_TIMEOUT+1).

## Timing
- Reset (rst=0): state=FETCH, instr_count=0, wait timer=0, halted=0, fault=0.
- Strobe outputs during and immediately after reset follow FETCH decoding: mem_req=1, mem_instr=1, all other strobes 0.
- Reset is asynchronous: asserting it mid-operation forces state and all registered outputs at once, without waiting for a clock edge. Deassertion is synchronized externally.
- Strobe outputs are combinational from state and inputs. ir_load, pc_en and the MEM exit are Mealy on mem_ready.
- Latency with zero-wait memory (mem_ready=1 on the first request cycle):
  - branch: 3 cycles
  - data-reg / data-imm: 4 cycles
  - store: 4 cycles
  - load: 5 cycles
  - Each memory wait cycle adds 1.
- mem_req stays high, with constant mem_we and mem_instr, until mem_ready. There is no mid-request abort except reset or timeout.

## Structure
- Package cpu_ctrl_pkg holds:
  - the state encodings (3-bit localparams/enum)
  - the MEM_TIMEOUT default
  - pc_sel constants PC_SEQ=0, PC_BR=1
- One sub-module, mem_wait_timer:
  - Inputs: clear, count enable.
  - Output: expired flag.
  - Parameterized by MEM_TIMEOUT.

## Test plan
- Data-imm instruction, mem_ready=1 at once → state sequence 0,1,2,4,0. rf_we pulses in cycle 4; instr_count 0→1.
- Branch with branch_taken=1 → pc_en=1, pc_sel=1 in EXEC, back to FETCH after 3 cycles. Repeat with branch_taken=0 → pc_sel=0.
- Load with mem_ready delayed by 3 cycles in MEM → mem_req=1, mem_we=0, mem_instr=0 held for 4 cycles, then WB, rf_we=1. A store instead → mem_we=1, no WB.
- mem_ready held at 0 in FETCH with MEM_TIMEOUT=15 → FAULT after 16 cycles, fault=1 sticky. Same case with mem_ready=1 on the expiry cycle → DECODE.
- dec_halt=1 together with dec_data_reg=1 → HALT; halted=1; instr_count unchanged; no strobes for 20 cycles.
- Force instr_count to 0xFFFFFFFF, retire once → 0. Assert rst mid-MEM → state=0 and instr_count=0 immediately, before the next clock edge.
